cga_text_serializer: RTL and testbench
======================================

Name: cga_text_serializer

Overview:
- Downstream of the crtc6845 timing generator in the CGA text path.
- Once per character slot, it takes the CRTC's mem_addr, row_addr, display_enable, cursor, hsync and vsync.
- It fetches the character/attribute word from VRAM over a req/ack handshake and looks up the font row in a synchronous font ROM.
- It serializes 8 pixels as 4-bit colour indices, with sync and enable delayed to match the pixel pipeline.

Parameters:
FONT_LAT, 1, clk cycles from font_addr valid to font_data valid (1..3).
FONT_H_BITS, 3, row_addr bits used for the font row (3 = 8x8 font, 4 = 8x16 font).

Ports:
clk  in  1  system clock; the CRTC runs on the same clock.
rst_n  in  1  asynchronous active-low reset.
pix_ce  in  1  pixel enable, one per pixel.
char_ce  in  1  character strobe (the CRTC divclk); always coincides with pix_ce on the last pixel of a character.
mem_addr  in  14  CRTC character address.
row_addr  in  5  CRTC scanline within the row.
de_in  in  1  CRTC display_enable.
cursor_in  in  1  CRTC cursor.
hsync_in  in  1  CRTC hsync.
vsync_in  in  1  CRTC vsync.
blink_en  in  1  mode bit: 1 = attr[7] means blink, 0 = attr[7] means background intensity.
clr_late  in  1  clears vram_late.
vram_req  out  1  read request; held until ack.
vram_addr  out  14  word address = latched mem_addr.
vram_ack  in  1  one-cycle pulse; vram_data is valid in the same cycle.
vram_data  in  16  [7:0] character code, [15:8] attribute.
font_addr  out  8+FONT_H_BITS  {char, row[FONT_H_BITS-1:0]}.
font_data  in  8  font row; MSB is the leftmost pixel.
pixel  out  4  colour index.
de_out  out  1  delayed enable.
hsync_out  out  1  delayed hsync.
vsync_out  out  1  delayed vsync.
vram_late  out  1  sticky fetch-overrun flag.

Behaviour:
- Reset: all outputs, every pipeline register and the blink counter go to 0. Reset asserted mid-fetch drops vram_req immediately; an ack arriving after reset is ignored.
- Stage A (fetch), on char_ce:
  - Latch mem_addr, row_addr, de_in, cursor_in, hsync_in and vsync_in.
  - If de_in=1: set vram_req=1 next cycle with vram_addr=mem_addr, and clear the fetched flag.
  - If de_in=0: no request; the slot is treated as fetched-blank.
- Handshake:
  - vram_req falls on the cycle after vram_ack.
  - An ack while req=0 is ignored.
  - On ack: latch the attribute and drive font_addr the next cycle.
  - After FONT_LAT further cycles, latch font_data and set fetched=1.
- Stage B (display), on the next char_ce:
  - Load the shift register with the font row and latch attr, cursor, de and syncs from stage A. Stage A then begins the next fetch in the same cycle.
  - If de=1 and fetched=0 (including an ack coinciding with char_ce): load font=0, attr=0 and set vram_late. The outstanding request is abandoned, req drops, and stage A restarts.
  - clr_late clears vram_late. If a set condition occurs in the same cycle, the set wins.
- Serializer: on each pix_ce after a load, shift left. The pixel bit is the shifter MSB, OR'd with the latched cursor.
- Colour:
  - fg = attr[3:0].
  - bg = {attr[7]&~blink_en, attr[6:4]}.
  - If blink_en and attr[7] and blink_cnt[4]=0: bit forced to 0 (character hidden, cursor unaffected).
  - pixel = bit ? fg : bg when latched de=1; otherwise 0.
  - pixel is registered on pix_ce.
- Blink counter: 5-bit, increments on each rising edge of vsync_in and wraps 31 to 0.
- Alignment: de_out, hsync_out and vsync_out equal the stage-B latched values, registered on pix_ce alongside pixel. Total latency from CRTC sample to the first pixel is one character slot plus one pix_ce.
- Fetch budget: ack must occur at least FONT_LAT+1 cycles before the next char_ce.

Test Plan:
- Reset mid-request: assert rst_n=0 while vram_req=1 → req=0 and pixel=0 immediately; a following ack is ignored, with no state change.
- Normal character: data 16'h1E41 ('A', yellow on blue), font row 8'b00111100, ack 2 cycles after req → 8 pixels 1,1,E,E,E,E,1,1, each on successive pix_ce starting one pix_ce after the second char_ce.
- Late ack: ack coinciding with char_ce → vram_late=1 and slot pixels all 0. Pulse clr_late → vram_late=0.
- Blink: attr 8'h87, blink_en=1, font 8'hFF → pixels 0 for vsync edges 0..15 and 7 for edges 16..31. With blink_en=0 and attr 8'h87 → bg=8, fg=7.
- Cursor: cursor_in=1, font 8'h00, attr 8'h0A → all 8 pixels = A.
- Blanking: de_in=0 → no vram_req, pixel=0 and de_out=0. hsync_out follows hsync_in delayed by exactly 8 pix_ce plus 1.

Source files
------------

// File: rtl/cga_text_serializer.sv
// -----------------------------------------------------------------------------
// cga_text_serializer
//
// CGA text-mode pixel path sitting behind the 6845 CRTC. Each character slot
// the CRTC address/scanline/enable/cursor/sync values are captured (stage A),
// the char/attr word is fetched from VRAM over a req/ack handshake and the font
// row is read from a synchronous font ROM. On the next character strobe the
// row is moved into the display stage (stage B) and shifted out MSB first as
// 4-bit colour indices, with enable and syncs delayed by the same amount.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   pix_ce_i         one pulse per pixel
//   char_ce_i        character strobe, coincides with the last pix_ce of a slot
//   mem_addr_i       CRTC character address (14b)
//   row_addr_i       CRTC scanline within the text row (5b)
//   de_in_i          CRTC display enable
//   cursor_in_i      CRTC cursor
//   hsync_in_i       CRTC hsync
//   vsync_in_i       CRTC vsync (also clocks the blink counter)
//   blink_en_i       1: attr[7] blinks, 0: attr[7] is background intensity
//   clr_late_i       clears the sticky vram_late flag
//   vram_req_o       VRAM read request, held until ack
//   vram_addr_o      VRAM word address (latched mem_addr)
//   vram_ack_i       one-cycle ack, vram_data_i valid with it
//   vram_data_i      [7:0] character code, [15:8] attribute
//   font_addr_o      {char, row[FONT_H_BITS-1:0]} to the font ROM
//   font_data_i      font row, MSB = leftmost pixel
//   pixel_o          colour index
//   de_out_o         delayed display enable
//   hsync_out_o      delayed hsync
//   vsync_out_o      delayed vsync
//   vram_late_o      sticky flag: a displayed slot was not fetched in time
// -----------------------------------------------------------------------------
module cga_text_serializer #(
    parameter int FONT_LAT    = 1,
    parameter int FONT_H_BITS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pix_ce_i,
    input  logic                     char_ce_i,
    input  logic [13:0]              mem_addr_i,
    input  logic [4:0]               row_addr_i,
    input  logic                     de_in_i,
    input  logic                     cursor_in_i,
    input  logic                     hsync_in_i,
    input  logic                     vsync_in_i,
    input  logic                     blink_en_i,
    input  logic                     clr_late_i,
    output logic                     vram_req_o,
    output logic [13:0]              vram_addr_o,
    input  logic                     vram_ack_i,
    input  logic [15:0]              vram_data_i,
    output logic [8+FONT_H_BITS-1:0] font_addr_o,
    input  logic [7:0]               font_data_i,
    output logic [3:0]               pixel_o,
    output logic                     de_out_o,
    output logic                     hsync_out_o,
    output logic                     vsync_out_o,
    output logic                     vram_late_o
);

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_FONT,
        FETCH_DONE
    } fetchState_e;

    localparam logic [1:0] LAT_LAST = 2'(FONT_LAT);

    fetchState_e state_q, state_d;
    logic [1:0]  latCnt_q, latCnt_d;

    logic [13:0]            aAddr_q;
    logic [FONT_H_BITS-1:0] aRow_q;
    logic                   aDe_q, aCursor_q, aHsync_q, aVsync_q;
    logic [7:0]             aAttr_q;
    logic [7:0]             fontRow_q;
    logic [8+FONT_H_BITS-1:0] fontAddr_q;

    logic [7:0] shift_q;
    logic [7:0] bAttr_q;
    logic       bCursor_q, bDe_q, bHsync_q, bVsync_q;

    logic [3:0] pixel_q, pixel_d;
    logic       deOut_q, hsOut_q, vsOut_q;
    logic       late_q;
    logic [4:0] blinkCnt_q;
    logic       vsPrev_q;

    logic       fontReady, ackTake, fontTake, lateSet;
    logic [7:0] loadRow, loadAttr;
    logic       hide, pixBit;
    logic [3:0] fg, bg;

    // Only the low scanline bits address the font; the rest are deliberately dropped.
    logic unusedRowBits;
    assign unusedRowBits = ^row_addr_i[4:FONT_H_BITS];

    // Fetch sequencer. A character strobe always restarts the fetch for the slot
    // just sampled, abandoning anything still outstanding. The font row counts as
    // ready in the exact cycle it is latched, so a fetch that just meets its
    // budget is not reported late.
    always_comb begin
        state_d   = state_q;
        latCnt_d  = latCnt_q;
        ackTake   = 1'b0;
        fontTake  = 1'b0;
        fontReady = (state_q == FETCH_DONE) ||
                    ((state_q == FETCH_FONT) && (latCnt_q == LAT_LAST));
        if (char_ce_i) begin
            state_d  = de_in_i ? FETCH_REQ : FETCH_IDLE;
            latCnt_d = 2'd0;
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    if (vram_ack_i) begin
                        state_d  = FETCH_FONT;
                        latCnt_d = 2'd0;
                        ackTake  = 1'b1;
                    end
                end
                FETCH_FONT: begin
                    if (latCnt_q == LAT_LAST) begin
                        state_d  = FETCH_DONE;
                        fontTake = 1'b1;
                    end else begin
                        latCnt_d = latCnt_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
        lateSet  = char_ce_i && aDe_q && !fontReady;
        loadRow  = 8'h00;
        loadAttr = 8'h00;
        if (aDe_q && fontReady) begin
            loadRow  = (state_q == FETCH_DONE) ? fontRow_q : font_data_i;
            loadAttr = aAttr_q;
        end
    end

    // Stage A registers: CRTC sample, fetch state, attribute and font row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_IDLE;
            latCnt_q   <= 2'd0;
            aAddr_q    <= '0;
            aRow_q     <= '0;
            aDe_q      <= 1'b0;
            aCursor_q  <= 1'b0;
            aHsync_q   <= 1'b0;
            aVsync_q   <= 1'b0;
            aAttr_q    <= 8'h00;
            fontAddr_q <= '0;
            fontRow_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            latCnt_q <= latCnt_d;
            if (char_ce_i) begin
                aAddr_q   <= mem_addr_i;
                aRow_q    <= row_addr_i[FONT_H_BITS-1:0];
                aDe_q     <= de_in_i;
                aCursor_q <= cursor_in_i;
                aHsync_q  <= hsync_in_i;
                aVsync_q  <= vsync_in_i;
            end
            if (ackTake) begin
                aAttr_q    <= vram_data_i[15:8];
                fontAddr_q <= {vram_data_i[7:0], aRow_q};
            end
            if (fontTake) begin
                fontRow_q <= font_data_i;
            end
        end
    end

    // Stage B: load on the character strobe, otherwise shift one pixel per pix_ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= 8'h00;
            bAttr_q   <= 8'h00;
            bCursor_q <= 1'b0;
            bDe_q     <= 1'b0;
            bHsync_q  <= 1'b0;
            bVsync_q  <= 1'b0;
        end else if (char_ce_i) begin
            shift_q   <= loadRow;
            bAttr_q   <= loadAttr;
            bCursor_q <= aCursor_q;
            bDe_q     <= aDe_q;
            bHsync_q  <= aHsync_q;
            bVsync_q  <= aVsync_q;
        end else if (pix_ce_i) begin
            shift_q <= {shift_q[6:0], 1'b0};
        end
    end

    // Colour lookup. A blinking character is hidden during the first half of the
    // blink period, but the cursor still shows through.
    always_comb begin
        hide    = blink_en_i && bAttr_q[7] && !blinkCnt_q[4];
        pixBit  = (shift_q[7] && !hide) || bCursor_q;
        fg      = bAttr_q[3:0];
        bg      = {bAttr_q[7] & ~blink_en_i, bAttr_q[6:4]};
        pixel_d = 4'h0;
        if (bDe_q) begin
            pixel_d = pixBit ? fg : bg;
        end
    end

    // Output register; enable and syncs travel with the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= 4'h0;
            deOut_q <= 1'b0;
            hsOut_q <= 1'b0;
            vsOut_q <= 1'b0;
        end else if (pix_ce_i) begin
            pixel_q <= pixel_d;
            deOut_q <= bDe_q;
            hsOut_q <= bHsync_q;
            vsOut_q <= bVsync_q;
        end
    end

    // Sticky late flag (a new overrun beats a clear) and the vsync blink counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            late_q     <= 1'b0;
            blinkCnt_q <= 5'd0;
            vsPrev_q   <= 1'b0;
        end else begin
            if (lateSet) begin
                late_q <= 1'b1;
            end else if (clr_late_i) begin
                late_q <= 1'b0;
            end
            vsPrev_q <= vsync_in_i;
            if (vsync_in_i && !vsPrev_q) begin
                blinkCnt_q <= blinkCnt_q + 5'd1;
            end
        end
    end

    assign vram_req_o  = (state_q == FETCH_REQ);
    assign vram_addr_o = aAddr_q;
    assign font_addr_o = fontAddr_q;
    assign pixel_o     = pixel_q;
    assign de_out_o    = deOut_q;
    assign hsync_out_o = hsOut_q;
    assign vsync_out_o = vsOut_q;
    assign vram_late_o = late_q;

endmodule

// File: tb/tb_cga_text_serializer.sv
// -----------------------------------------------------------------------------
// tb_cga_text_serializer
//
// Directed bench for cga_text_serializer. The bench plays the CRTC (8-pixel
// slots, one pix_ce per clock), the VRAM (hand-timed ack pulses) and a one-cycle
// synchronous font ROM. Expected pixel rows are hand-computed from the attribute
// and font row of each character.
// -----------------------------------------------------------------------------
module tb_cga_text_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_ce, char_ce;
    logic [13:0] mem_addr;
    logic [4:0]  row_addr;
    logic        de_in, cursor_in, hsync_in, vsync_in;
    logic        blink_en, clr_late;
    logic        vram_req;
    logic [13:0] vram_addr;
    logic        vram_ack;
    logic [15:0] vram_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [3:0]  pixel;
    logic        de_out, hsync_out, vsync_out, vram_late;

    int errorCount = 0;
    int checkCount = 0;

    // CRTC values presented for the slot being run
    logic [13:0] memAddr;
    logic [4:0]  row;
    logic        de, cursor, hs, clrLate;

    // Captures from the most recent slot, first pixel in the top nibble/bit
    logic [31:0] pixCap;
    logic [7:0]  hsCap, deCap;
    logic [13:0] addrAtAck;
    logic        reqSeen;

    logic [7:0] romMem [0:2047];

    cga_text_serializer #(.FONT_LAT(1), .FONT_H_BITS(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_ce_i    (pix_ce),
        .char_ce_i   (char_ce),
        .mem_addr_i  (mem_addr),
        .row_addr_i  (row_addr),
        .de_in_i     (de_in),
        .cursor_in_i (cursor_in),
        .hsync_in_i  (hsync_in),
        .vsync_in_i  (vsync_in),
        .blink_en_i  (blink_en),
        .clr_late_i  (clr_late),
        .vram_req_o  (vram_req),
        .vram_addr_o (vram_addr),
        .vram_ack_i  (vram_ack),
        .vram_data_i (vram_data),
        .font_addr_o (font_addr),
        .font_data_i (font_data),
        .pixel_o     (pixel),
        .de_out_o    (de_out),
        .hsync_out_o (hsync_out),
        .vsync_out_o (vsync_out),
        .vram_late_o (vram_late)
    );

    always #5 clk = ~clk;

    // Synchronous font ROM, one cycle of latency
    always @(posedge clk) font_data <= romMem[font_addr];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One 8-pixel character slot. CRTC inputs are sampled by the DUT on the
    // char_ce of the last pixel; ackAt (0..7, or -1) places a VRAM ack.
    task automatic applyStimulus(input int ackAt, input logic [15:0] ackData);
        reqSeen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pix_ce    = 1'b1;
            char_ce   = (k == 7);
            mem_addr  = memAddr;
            row_addr  = row;
            de_in     = de;
            cursor_in = cursor;
            hsync_in  = hs;
            clr_late  = clrLate;
            vram_ack  = (k == ackAt);
            vram_data = (k == ackAt) ? ackData : 16'h0000;
            if (k == ackAt) addrAtAck = vram_addr;
            reqSeen = reqSeen | vram_req;
            @(posedge clk);
            #1;
            pixCap = {pixCap[27:0], pixel};
            hsCap  = {hsCap[6:0], hsync_out};
            deCap  = {deCap[6:0], de_out};
        end
        pix_ce   = 1'b0;
        char_ce  = 1'b0;
        vram_ack = 1'b0;
        clr_late = 1'b0;
    endtask

    // Sample a character, fetch it (ack 2 cycles after req), then display it.
    task automatic showChar(input logic [13:0] a, input logic [4:0] r, input logic cur, input logic [15:0] data);
        memAddr = a; row = r; de = 1'b1; cursor = cur;
        applyStimulus(-1, 16'h0);
        de = 1'b0; cursor = 1'b0;
        applyStimulus(2, data);
        applyStimulus(-1, 16'h0);
    endtask

    task automatic pulseVsync(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) vsync_in = 1'b1;
            @(negedge clk) vsync_in = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) romMem[i] = 8'h00;
        romMem[{8'h41, 3'd2}] = 8'b0011_1100;
        romMem[{8'hDB, 3'd0}] = 8'hFF;
        romMem[{8'hDB, 3'd1}] = 8'hF0;

        rst_n = 1'b0; pix_ce = 1'b0; char_ce = 1'b0; mem_addr = '0; row_addr = '0;
        de_in = 1'b0; cursor_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        blink_en = 1'b0; clr_late = 1'b0; vram_ack = 1'b0; vram_data = '0;
        memAddr = '0; row = '0; de = 1'b0; cursor = 1'b0; hs = 1'b0; clrLate = 1'b0;
        pixCap = '0; hsCap = '0; deCap = '0; addrAtAck = '0; reqSeen = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_pixel", 32'(pixel), 32'h0);
        checkOutput("rst_req", 32'(vram_req), 32'h0);
        checkOutput("rst_late", 32'(vram_late), 32'h0);
        checkOutput("rst_de_out", 32'(de_out), 32'h0);
        checkOutput("rst_font_addr", 32'(font_addr), 32'h0);
        checkOutput("rst_vsync_out", 32'(vsync_out), 32'h0);
        rst_n = 1'b1;

        // Reset in the middle of a request; later acks must be ignored
        memAddr = 14'h0123; row = 5'd2; de = 1'b1;
        applyStimulus(-1, 16'h0);
        checkOutput("midreq_req_up", 32'(vram_req), 32'h1);
        checkOutput("midreq_addr", 32'(vram_addr), 32'h0123);
        @(negedge clk) rst_n = 1'b0;
        #1;
        checkOutput("midreq_req_drop", 32'(vram_req), 32'h0);
        checkOutput("midreq_pixel", 32'(pixel), 32'h0);
        @(negedge clk) begin vram_ack = 1'b1; vram_data = 16'h1E41; end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) vram_ack = 1'b0;
        @(negedge clk);
        checkOutput("midreq_ack_ignored_req", 32'(vram_req), 32'h0);
        checkOutput("midreq_ack_ignored_font", 32'(font_addr), 32'h0);

        // Normal character 'A', yellow on blue
        showChar(14'h0200, 5'd2, 1'b0, 16'h1E41);
        checkOutput("normal_vram_addr", 32'(addrAtAck), 32'h0200);
        checkOutput("normal_font_addr", 32'(font_addr), 32'({8'h41, 3'd2}));
        checkOutput("normal_pixels", pixCap, 32'h11EE_EE11);
        checkOutput("normal_de_out", 32'(deCap), 32'hFF);
        checkOutput("normal_not_late", 32'(vram_late), 32'h0);

        // Ack coinciding with char_ce is too late
        memAddr = 14'h0300; row = 5'd2; de = 1'b1;
        applyStimulus(-1, 16'h0);
        de = 1'b0;
        applyStimulus(7, 16'h1E41);
        checkOutput("late_flag", 32'(vram_late), 32'h1);
        checkOutput("late_req_dropped", 32'(vram_req), 32'h0);
        applyStimulus(-1, 16'h0);
        checkOutput("late_pixels", pixCap, 32'h0);
        checkOutput("late_de_out", 32'(deCap), 32'hFF);
        @(negedge clk) clr_late = 1'b1;
        @(negedge clk) clr_late = 1'b0;
        checkOutput("late_cleared", 32'(vram_late), 32'h0);
        de = 1'b1;
        applyStimulus(-1, 16'h0);
        de = 1'b0; clrLate = 1'b1;
        applyStimulus(7, 16'h1E41);
        clrLate = 1'b0;
        checkOutput("late_set_beats_clear", 32'(vram_late), 32'h1);
        @(negedge clk) clr_late = 1'b1;
        @(negedge clk) clr_late = 1'b0;

        // Blink: hidden for counter 0..15, shown for 16..31, wraps back to hidden
        blink_en = 1'b1;
        showChar(14'h0400, 5'd0, 1'b0, 16'h87DB);
        checkOutput("blink_cnt0_hidden", pixCap, 32'h0000_0000);
        pulseVsync(16);
        showChar(14'h0400, 5'd0, 1'b0, 16'h87DB);
        checkOutput("blink_cnt16_shown", pixCap, 32'h7777_7777);
        pulseVsync(15);
        showChar(14'h0400, 5'd0, 1'b0, 16'h87DB);
        checkOutput("blink_cnt31_shown", pixCap, 32'h7777_7777);
        pulseVsync(1);
        showChar(14'h0400, 5'd0, 1'b0, 16'h87DB);
        checkOutput("blink_wrap_hidden", pixCap, 32'h0000_0000);
        blink_en = 1'b0;
        showChar(14'h0400, 5'd1, 1'b0, 16'h87DB);
        checkOutput("intensity_bg", pixCap, 32'h7777_8888);

        // Cursor forces foreground, even over a hidden blinking character
        showChar(14'h0500, 5'd0, 1'b1, 16'h0A20);
        checkOutput("cursor_pixels", pixCap, 32'hAAAA_AAAA);
        blink_en = 1'b1;
        showChar(14'h0500, 5'd0, 1'b1, 16'h8A20);
        checkOutput("cursor_over_blink", pixCap, 32'hAAAA_AAAA);
        blink_en = 1'b0;

        // Blanking and sync delay
        de = 1'b0; cursor = 1'b0; hs = 1'b1;
        applyStimulus(-1, 16'h0);
        hs = 1'b0;
        applyStimulus(-1, 16'h0);
        checkOutput("blank_no_req", 32'(reqSeen), 32'h0);
        checkOutput("hsync_not_early", 32'(hsCap), 32'h00);
        applyStimulus(-1, 16'h0);
        checkOutput("hsync_delayed", 32'(hsCap), 32'hFF);
        checkOutput("blank_de_out", 32'(deCap), 32'h00);
        checkOutput("blank_pixels", pixCap, 32'h0);
        applyStimulus(-1, 16'h0);
        checkOutput("hsync_falls", 32'(hsCap), 32'h00);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
